ifetch_seq: RTL
===============

Name: ifetch_seq

Overview:
Instruction-fetch sequencer for the RISC-V core. It owns the PC and drives the I-cache read handshake (ren/stall). It buffers fetched words in a 2-entry queue toward decode. It applies redirects from EX and, optionally, predicts JAL targets using a local J-type immediate decode, which must match the core's immediate generator exactly.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
JAL_PREDICT, 1, 1 = redirect fetch to JAL target at fetch time; 0 = always fall through PC+4.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
icache_ren  out  1  I-cache read request; held high until completion.
icache_addr  out  30  word address = pc[31:2].
icache_rdata  in  32  instruction word; valid in any cycle with icache_ren=1 and icache_stall=0.
icache_stall  in  1  1 = request not complete.
redirect_valid  in  1  EX redirect (taken branch, JALR, mispredict), single-cycle pulse or level.
redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
if_valid  out  1  queue head valid (count != 0).
if_ready  in  1  decode accepts head; pop when if_valid & if_ready.
if_instr  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
if_pc  out  32  head PC; 0 when empty.
if_pred_taken  out  1  head was a predicted-taken JAL; 0 when empty.

Behaviour:
- Reset (async, any cycle, including mid-miss):
  - state=IDLE, pc=RESET_PC, queue count=0, busy=0.
  - icache_ren=0 immediately.
  - Outputs return to empty values.
- States: IDLE, FETCH, FLUSH.
- IDLE: icache_ren=0; next cycle goes to FETCH.
- FETCH:
  - icache_ren = busy | (count<2).
  - busy is set when ren=1 and stall=1, and cleared on completion.
  - Once ren is high it never drops before completion, except on reset.
  - Completion (ren=1, stall=0): push {rdata, pc, pred} into the queue in the same edge. pc <= next_pc.
  - A new request can start in the same cycle as a completion. Back-to-back hits sustain 1 instr/cycle.
- next_pc:
  - If JAL_PREDICT=1, rdata[6:0]=7'b1101111, and target[1]=0: next_pc = target, where target = pc + sext({rdata[31], rdata[19:12], rdata[20], rdata[30:21], 1'b0}). pred=1.
  - Otherwise next_pc = pc+4, pred=0. This covers a misaligned JAL target: no prediction, and EX handles it.
  - Arithmetic is 32-bit and wraps modulo 2^32. PC 32'hFFFF_FFFC +4 gives 0.
- Queue:
  - 2 entries, FIFO order.
  - Push and pop in the same cycle are both honoured.
  - Overflow cannot occur because a request only starts when count<2. Bench asserts count<=2.
- Redirect (redirect_valid=1 at an edge), highest priority over completion, pop and prediction:
  - count <= 0 and pc <= {redirect_pc[31:2], 2'b00}.
  - If busy=1, or the current cycle has ren=1 & stall=1: go to FLUSH.
  - If the current cycle completes (ren=1, stall=0): data is discarded, stay in FETCH at the new pc.
  - If no request is active: stay in FETCH.
  - A redirect arriving in IDLE updates pc; the transition to FETCH proceeds normally.
- FLUSH:
  - icache_ren=1 and icache_addr holds the in-flight request address until stall=0.
  - Data is discarded, no push.
  - Then go to FETCH using the redirected pc.
  - A further redirect in FLUSH overwrites pc and stays in FLUSH.
  - The queue is empty throughout (if_valid=0).
- icache_addr:
  - In FETCH it equals pc[31:2].
  - In FLUSH it equals the latched address of the outstanding request.

Test Plan:
- Reset release, RESET_PC=0, always hit, if_ready=1 -> addresses 0,1,2,... on consecutive cycles. if_pc 0,4,8 with if_valid=1 each cycle from the 3rd cycle.
- Back-pressure: if_ready=0, always hit -> exactly 2 pushes (if_pc 0,4). icache_ren=0 afterwards, count=2, no overflow. Raise if_ready -> fetch resumes at pc 8.
- Miss at pc 0x10 with stall=1 for 5 cycles, redirect_pc=0x200 in cycle 2 -> ren stays high with addr 0x4 until stall falls. Word discarded, next request addr 0x80, first if_pc=0x200.
- Fetch 32'h0100_006F (JAL x0,+16) at pc 0x40 -> next addr 0x14 (pc 0x50), head if_pred_taken=1. With JAL_PREDICT=0 -> next pc 0x44, pred 0.
- JAL 32'h0020_006F (offset +2, misaligned) at pc 0x40 -> next pc 0x44, pred 0.
- Assert rst_n low mid-miss -> icache_ren=0, if_valid=0, if_instr=0x13 without waiting for a clock edge. Release -> fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_seq_if.sv
// Fetch-side bundle: I-cache read handshake, EX redirect and the decode queue head.
interface ifetch_seq_if;
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic [31:0] icache_rdata;
  logic        icache_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_pred_taken;

  // Sequencer side
  modport master (
    output icache_ren, icache_addr,
    input  icache_rdata, icache_stall,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_pred_taken,
    input  if_ready
  );

  // Cache / EX / decode side
  modport slave (
    input  icache_ren, icache_addr,
    output icache_rdata, icache_stall,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pred_taken,
    output if_ready
  );
endinterface

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: owns the PC, issues I-cache reads, optionally
// follows JAL targets at fetch time, and feeds a 2-entry queue toward decode.
// A redirect that lands while a miss is outstanding parks in FLUSH so the
// stale request finishes at its original address and its data is dropped.
module ifetch_seq #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          JAL_PREDICT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  ifetch_seq_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FLUSH = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        busy_reg, busy_next;
  logic [29:0] flush_addr_reg, flush_addr_next;
  logic [1:0]  count_reg, count_next;
  logic        head_reg, head_next;

  logic [31:0] q_instr_reg [2];
  logic [31:0] q_pc_reg    [2];
  logic        q_pred_reg  [2];

  logic        ren, push, pop, wr_idx;
  logic [31:0] redirect_target, jal_imm, jal_target, fetch_next_pc;
  logic        fetch_pred;

  // Low two bits of the redirect target are meaningless for 32-bit fetch.
  assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

  // J-type immediate, bit-for-bit identical to the core's immediate generator.
  assign jal_imm = {{11{bus.icache_rdata[31]}}, bus.icache_rdata[31],
                    bus.icache_rdata[19:12], bus.icache_rdata[20],
                    bus.icache_rdata[30:21], 1'b0};
  assign jal_target = pc_reg + jal_imm;

  // A halfword-aligned JAL target is left for EX to trap on, so no prediction.
  assign fetch_pred    = JAL_PREDICT && (bus.icache_rdata[6:0] == 7'b1101111) && !jal_target[1];
  assign fetch_next_pc = fetch_pred ? jal_target : pc_reg + 32'd4;

  assign pop    = (count_reg != 2'd0) && bus.if_ready;
  assign wr_idx = head_reg ^ count_reg[0];

  // Next-state, request and queue bookkeeping
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    busy_next       = busy_reg;
    flush_addr_next = flush_addr_reg;
    count_next      = count_reg;
    head_next       = head_reg;
    ren             = 1'b0;
    push            = 1'b0;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        if (bus.redirect_valid) pc_next = redirect_target;
      end
      FETCH: begin
        // Once raised, busy keeps ren high until the cache completes.
        ren = busy_reg | (count_reg != 2'd2);
        if (bus.redirect_valid) begin
          pc_next    = redirect_target;
          count_next = 2'd0;
          head_next  = 1'b0;
          busy_next  = 1'b0;
          if (ren && bus.icache_stall) begin
            state_next      = FLUSH;
            flush_addr_next = pc_reg[31:2];
          end
        end else begin
          if (ren && !bus.icache_stall) begin
            push      = 1'b1;
            pc_next   = fetch_next_pc;
            busy_next = 1'b0;
          end else if (ren) begin
            busy_next = 1'b1;
          end
          count_next = count_reg + {1'b0, push} - {1'b0, pop};
          head_next  = head_reg ^ pop;
        end
      end
      FLUSH: begin
        ren = 1'b1;
        if (bus.redirect_valid) pc_next = redirect_target;
        if (!bus.icache_stall) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pc_reg         <= RESET_PC;
      busy_reg       <= 1'b0;
      flush_addr_reg <= '0;
      count_reg      <= 2'd0;
      head_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      busy_reg       <= busy_next;
      flush_addr_reg <= flush_addr_next;
      count_reg      <= count_next;
      head_reg       <= head_next;
    end
  end

  // Queue storage: write the completed word into the slot behind the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        q_instr_reg[i] <= NOP;
        q_pc_reg[i]    <= '0;
        q_pred_reg[i]  <= 1'b0;
      end
    end else if (push) begin
      q_instr_reg[wr_idx] <= bus.icache_rdata;
      q_pc_reg[wr_idx]    <= pc_reg;
      q_pred_reg[wr_idx]  <= fetch_pred;
    end
  end

  assign bus.icache_ren    = ren;
  assign bus.icache_addr   = (state_reg == FLUSH) ? flush_addr_reg : pc_reg[31:2];
  assign bus.if_valid      = (count_reg != 2'd0);
  assign bus.if_instr      = bus.if_valid ? q_instr_reg[head_reg] : NOP;
  assign bus.if_pc         = bus.if_valid ? q_pc_reg[head_reg] : 32'd0;
  assign bus.if_pred_taken = bus.if_valid && q_pred_reg[head_reg];
endmodule
